multi_digit_seg_scanner: RTL and testbench

MULTI_DIGIT_SEG_SCANNER -- requirements
Module: multi_digit_seg_scanner

---
 rtl/seg_scan_pkg.sv | 37 +++
 rtl/seg_hex_decoder.sv | 17 +
 rtl/multi_digit_seg_scanner.sv | 211 +++++++++++++++++++++
 tb/tb_multi_digit_seg_scanner.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared constants for the multiplexed seven-segment scanner:
//   SEG_OFF      - segment pattern for a dark digit (before polarity inversion)
//   HEX_SEG      - 16-entry hex-to-segment table, bit0 = a ... bit6 = g
//   hex_to_seg() - table lookup helper used by seg_hex_decoder
// -----------------------------------------------------------------------------
package seg_scan_pkg;

   localparam logic [6:0] SEG_OFF = 7'h00;

   // Entry n is the glyph for nibble n; listed high index first because this
   // is a packed concatenation.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71,  // F
      7'h79,  // E
      7'h5E,  // d
      7'h39,  // C
      7'h7C,  // b
      7'h77,  // A
      7'h6F,  // 9
      7'h7F,  // 8
      7'h07,  // 7
      7'h7D,  // 6
      7'h6D,  // 5
      7'h66,  // 4
      7'h4F,  // 3
      7'h5B,  // 2
      7'h06,  // 1
      7'h3F   // 0
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
      return HEX_SEG[nibble];
   endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// -----------------------------------------------------------------------------
// seg_hex_decoder
// Purely combinational nibble to seven-segment decode (active-high segments).
// Ports:
//   nibble_i - hex digit 0..F
//   seg_o    - segments, bit0 = a ... bit6 = g
// -----------------------------------------------------------------------------
module seg_hex_decoder
   import seg_scan_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/multi_digit_seg_scanner.sv
// -----------------------------------------------------------------------------
// multi_digit_seg_scanner
// Time-multiplexed driver for NUM_DIGITS seven-segment digits. Each digit gets
// a slot of REFRESH_DIV clocks; the first BLANK_CYCLES of every slot keep all
// digit enables off so the previous digit's segments cannot ghost onto the
// next one. New values arrive through a valid/ready shadow register and are
// only copied to the display register at a frame end (or immediately while the
// scan is disabled), so a single frame never mixes old and new digits.
//
// Ports:
//   clk        - clock, all state on rising edge
//   reset      - asynchronous active-high reset
//   enable     - scan enable; when low the slot position holds, outputs go dark
//   value_in   - 4*NUM_DIGITS hex nibbles, digit 0 in bits [3:0]
//   dp_in      - live decimal-point request per digit
//   blank_lz   - suppress leading zeros (digit 0 is always shown)
//   load_valid - offer value_in to the shadow register
//   load_ready - shadow register free (combinational, = !pending)
//   seg        - registered segments, bit0 = a ... bit6 = g
//   dp         - registered decimal point
//   digit_sel  - registered one-hot digit enable, active high
//   frame_done - registered one-cycle pulse after the last slot of a frame
// -----------------------------------------------------------------------------
module multi_digit_seg_scanner
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 1024,
   parameter int BLANK_CYCLES   = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [4*NUM_DIGITS-1:0]   value_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic                      blank_lz,
   input  logic                      load_valid,
   output logic                      load_ready,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic [NUM_DIGITS-1:0]     digit_sel,
   output logic                      frame_done
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

   // Dark level as it appears on the pins, after polarity selection.
   localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
   localparam logic       DP_DARK  = SEG_ACTIVE_LOW;

   // ---------------------------------------------------------------------------
   // Parameter sanity checks (elaboration time only)
   // ---------------------------------------------------------------------------
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
      $error("NUM_DIGITS must be in 1..8");
   end
   if (REFRESH_DIV < 4) begin : g_bad_refresh_div
      $error("REFRESH_DIV must be at least 4");
   end
   if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
      $error("BLANK_CYCLES must be less than REFRESH_DIV");
   end

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0]        cnt_q,     cnt_d;
   logic [IDX_W-1:0]        idx_q,     idx_d;
   logic [4*NUM_DIGITS-1:0] display_q, display_d;
   logic [4*NUM_DIGITS-1:0] shadow_q,  shadow_d;
   logic                    pending_q, pending_d;

   logic [6:0]              seg_q,        seg_d;
   logic                    dp_q,         dp_d;
   logic [NUM_DIGITS-1:0]   digit_sel_q,  digit_sel_d;
   logic                    frame_done_q, frame_done_d;

   logic                    frame_end;
   logic                    load_accept;

   // ---------------------------------------------------------------------------
   // Slot counter, digit index and shadow/display transfer
   // ---------------------------------------------------------------------------
   assign frame_end   = enable && (idx_q == IDX_MAX) && (cnt_q == CNT_MAX);
   assign load_accept = load_valid && !pending_q;
   assign load_ready  = !pending_q;

   // NOTE: every signal written in an always_comb gets a default at the top of
   // the block; a path that leaves one unassigned would infer a latch.
   always_comb begin
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      display_d = display_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;

      if (enable) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      // Transfer uses pending_q, so a load accepted in this same cycle (only
      // possible when pending_q is low) waits for the next frame end.
      if (pending_q && (frame_end || !enable)) begin
         display_d = shadow_q;
         pending_d = 1'b0;
      end

      if (load_accept) begin
         shadow_d  = value_in;
         pending_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Digit selection and decode
   // ---------------------------------------------------------------------------
   logic [3:0]            nibble_arr [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] upper_zero;   // digit i and every digit above it are 0
   logic                  zero_run;
   logic [3:0]            cur_nibble;
   logic [6:0]            cur_seg;
   logic                  slot_active;
   logic                  lz_blank;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nibble
      assign nibble_arr[g] = display_q[4*g +: 4];
   end

   always_comb begin
      upper_zero = '0;
      zero_run   = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run      = zero_run && (nibble_arr[i] == 4'h0);
         upper_zero[i] = zero_run;
      end
   end

   assign cur_nibble  = nibble_arr[idx_q];
   assign slot_active = enable && (cnt_q >= CNT_BLANK);
   // Digit 0 is never a leading zero, so a value of 0 still shows "0".
   assign lz_blank    = blank_lz && (idx_q != '0) && upper_zero[idx_q];

   seg_hex_decoder u_dec (
      .nibble_i (cur_nibble),
      .seg_o    (cur_seg)
   );

   always_comb begin
      digit_sel_d  = '0;
      seg_d        = SEG_DARK;
      dp_d         = DP_DARK;
      frame_done_d = frame_end;

      if (slot_active) begin
         digit_sel_d[idx_q] = 1'b1;
         seg_d = lz_blank ? SEG_OFF : cur_seg;
         dp_d  = dp_in[idx_q];
         // Polarity is applied only to segment data, never to digit enables.
         if (SEG_ACTIVE_LOW) begin
            seg_d = ~seg_d;
            dp_d  = ~dp_d;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         display_q    <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         seg_q        <= SEG_DARK;
         dp_q         <= DP_DARK;
         digit_sel_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         display_q    <= display_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         digit_sel_q  <= digit_sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign digit_sel  = digit_sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_multi_digit_seg_scanner.sv
// -----------------------------------------------------------------------------
// tb_multi_digit_seg_scanner
// Directed bench for multi_digit_seg_scanner with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2. A frame is 32 clocks. After every rising edge the outputs
// reflect the slot position p held before that edge: digit d = p/8 is enabled
// when p%8 >= 2, and frame_done is high for p = 31. Expected segment patterns
// per digit are written out by hand for every frame.
// -----------------------------------------------------------------------------
module tb_multi_digit_seg_scanner;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        blank_lz;
   logic        load_valid;
   logic        load_ready;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  digit_sel;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int ld_hold = 0;

   multi_digit_seg_scanner #(
      .NUM_DIGITS     (4),
      .REFRESH_DIV    (8),
      .BLANK_CYCLES   (2),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .seg        (seg),
      .dp         (dp),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Runs one 32-clock frame starting from slot position 0 and checks every
   // output cycle. s0..s3 are the expected lit patterns of digits 0..3,
   // dpv the expected decimal points. When load_at >= 0, load_valid is raised
   // at that position with load_val and then held for two further cycles with
   // a junk value that must be refused.
   task automatic run_frame(input string tag,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpv,
                            input int load_at, input logic [15:0] load_val);
      logic [6:0] sv [4];
      logic [3:0] exp_sel;
      logic [6:0] exp_seg;
      logic       exp_dp;
      sv = '{s0, s1, s2, s3};
      for (int p = 0; p < 32; p++) begin
         if (p == load_at) begin
            check($sformatf("%s p%0d ready_before_load", tag, p), 32'(load_ready), 32'(1));
            load_valid = 1'b1;
            value_in   = load_val;
            ld_hold    = 3;
         end
         tick();
         exp_sel = '0;
         exp_seg = 7'h00;
         exp_dp  = 1'b0;
         if ((p % 8) >= 2) begin
            exp_sel[p / 8] = 1'b1;
            exp_seg        = sv[p / 8];
            exp_dp         = dpv[p / 8];
         end
         check($sformatf("%s p%0d digit_sel", tag, p), 32'(digit_sel), 32'(exp_sel));
         check($sformatf("%s p%0d seg", tag, p), 32'(seg), 32'(exp_seg));
         check($sformatf("%s p%0d dp", tag, p), 32'(dp), 32'(exp_dp));
         check($sformatf("%s p%0d frame_done", tag, p), 32'(frame_done), 32'(p == 31));
         if (ld_hold > 0) begin
            ld_hold--;
            check($sformatf("%s p%0d ready_low", tag, p), 32'(load_ready), 32'(0));
            value_in = 16'hEEEE;
            if (ld_hold == 0) load_valid = 1'b0;
         end
      end
   endtask

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      value_in   = 16'h0000;
      dp_in      = 4'b0000;
      blank_lz   = 1'b0;
      load_valid = 1'b0;

      // Outputs held at their reset values
      tick();
      tick();
      check("rst digit_sel", 32'(digit_sel), 32'(0));
      check("rst seg", 32'(seg), 32'(0));
      check("rst dp", 32'(dp), 32'(0));
      check("rst frame_done", 32'(frame_done), 32'(0));
      check("rst load_ready", 32'(load_ready), 32'(1));

      // Free-running scan of the reset value 0000
      reset  = 1'b0;
      enable = 1'b1;
      run_frame("f0", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, -1, 16'h0);

      // Mid-frame load: this frame still shows 0000, the next shows 12AF
      run_frame("f1", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 10, 16'h12AF);
      run_frame("f2", 7'h71, 7'h77, 7'h5B, 7'h06, 4'b0000, -1, 16'h0);

      // Leading-zero blanking with live decimal point on digit 2
      blank_lz = 1'b1;
      dp_in    = 4'b0100;
      run_frame("f3", 7'h71, 7'h77, 7'h5B, 7'h06, 4'b0100, 5, 16'h0030);
      run_frame("f4", 7'h3F, 7'h4F, 7'h00, 7'h00, 4'b0100, -1, 16'h0);

      // Load on the frame-end cycle waits a whole frame; junk loads refused
      blank_lz = 1'b0;
      dp_in    = 4'b0000;
      run_frame("f5", 7'h3F, 7'h4F, 7'h3F, 7'h3F, 4'b0000, 31, 16'h5000);
      run_frame("f6", 7'h3F, 7'h4F, 7'h3F, 7'h3F, 4'b0000, -1, 16'h0);
      run_frame("f7", 7'h3F, 7'h3F, 7'h3F, 7'h6D, 4'b0000, -1, 16'h0);

      // Disable with a load pending: dark outputs, immediate transfer, hold
      dp_in      = 4'b1111;
      load_valid = 1'b1;
      value_in   = 16'h9876;
      tick();
      load_valid = 1'b0;
      enable     = 1'b0;
      check("dis pending ready", 32'(load_ready), 32'(0));
      tick();
      check("dis ready", 32'(load_ready), 32'(1));
      check("dis digit_sel", 32'(digit_sel), 32'(0));
      check("dis seg", 32'(seg), 32'(0));
      check("dis dp", 32'(dp), 32'(0));
      check("dis frame_done", 32'(frame_done), 32'(0));
      tick();
      check("dis hold digit_sel", 32'(digit_sel), 32'(0));
      enable = 1'b1;
      tick();
      check("resume p1 digit_sel", 32'(digit_sel), 32'(0));
      tick();
      check("resume p2 digit_sel", 32'(digit_sel), 32'(1));
      check("resume p2 seg", 32'(seg), 32'(7'h7D));
      check("resume p2 dp", 32'(dp), 32'(1));

      // Asynchronous reset mid-slot with a load pending
      load_valid = 1'b1;
      value_in   = 16'hAAAA;
      tick();
      load_valid = 1'b0;
      check("pre-rst ready", 32'(load_ready), 32'(0));
      #2;
      reset = 1'b1;
      #1;
      check("async digit_sel", 32'(digit_sel), 32'(0));
      check("async seg", 32'(seg), 32'(0));
      check("async dp", 32'(dp), 32'(0));
      check("async frame_done", 32'(frame_done), 32'(0));
      check("async load_ready", 32'(load_ready), 32'(1));
      @(negedge clk);
      reset = 1'b0;
      dp_in = 4'b0000;
      run_frame("post_rst", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, -1, 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
